// File: rtl/ma_mrf_dispatcher_pkg.sv
// ma_pkg: shared state encoding, command record and beat-size helper for the
// MRF load dispatcher.
package ma_pkg;
  localparam int unsigned MA_NUM_MRF        = 4;
  localparam int unsigned MA_DDR4_ADDRWIDTH = 36;
  localparam int unsigned MA_MRF_ADDRWIDTH  = 6;
  localparam int unsigned MA_MRF_DATAWIDTH  = 1024;
  localparam int unsigned MA_BYTES_WIDTH    = 15;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} ma_disp_state_e;

  // Matrix-load command as issued by ma_controller (default-width build).
  typedef struct packed {
    logic [MA_DDR4_ADDRWIDTH-1:0] src;
    logic [MA_MRF_ADDRWIDTH-1:0]  dst;
    logic [MA_BYTES_WIDTH-1:0]    bytes;
    logic [MA_NUM_MRF-1:0]        mask;
  } ma_mrf_cmd_t;

  function automatic int unsigned ma_beat_bytes(input int unsigned data_width);
    return data_width / 8;
  endfunction
endpackage

// File: rtl/ma_mrf_dispatcher_if.sv
// ma_mrf_dispatcher_if: command/completion channel from ma_controller plus the
// per-channel datamover start/done bus. slave = dispatcher view.
interface ma_mrf_dispatcher_if #(
  parameter int unsigned NUM_MRF        = 4,
  parameter int unsigned DDR4_ADDRWIDTH = 36,
  parameter int unsigned MRF_ADDRWIDTH  = 6,
  parameter int unsigned BYTES_WIDTH    = 15
);
  logic                                     cmd_valid_i;
  logic                                     cmd_ready_o;
  logic [DDR4_ADDRWIDTH-1:0]                cmd_src_addr_i;
  logic [MRF_ADDRWIDTH-1:0]                 cmd_dst_bram_addr_i;
  logic [BYTES_WIDTH-1:0]                   cmd_bytes_i;
  logic [NUM_MRF-1:0]                       cmd_ch_mask_i;
  logic                                     done_o;
  logic                                     err_o;
  logic [NUM_MRF-1:0]                       err_ch_o;
  logic                                     timeout_o;
  logic                                     busy_o;
  logic [NUM_MRF-1:0]                       dm_start_o;
  logic [NUM_MRF-1:0][DDR4_ADDRWIDTH-1:0]   dm_src_axi_addr_o;
  logic [NUM_MRF-1:0][MRF_ADDRWIDTH-1:0]    dm_dst_bram_addr_o;
  logic [NUM_MRF-1:0][BYTES_WIDTH-1:0]      dm_byte_to_trans_o;
  logic [NUM_MRF-1:0]                       dm_done_i;
  logic [NUM_MRF-1:0]                       dm_err_i;

  modport slave (
    input  cmd_valid_i, cmd_src_addr_i, cmd_dst_bram_addr_i, cmd_bytes_i,
           cmd_ch_mask_i, dm_done_i, dm_err_i,
    output cmd_ready_o, done_o, err_o, err_ch_o, timeout_o, busy_o,
           dm_start_o, dm_src_axi_addr_o, dm_dst_bram_addr_o, dm_byte_to_trans_o
  );

  modport master (
    output cmd_valid_i, cmd_src_addr_i, cmd_dst_bram_addr_i, cmd_bytes_i,
           cmd_ch_mask_i, dm_done_i, dm_err_i,
    input  cmd_ready_o, done_o, err_o, err_ch_o, timeout_o, busy_o,
           dm_start_o, dm_src_axi_addr_o, dm_dst_bram_addr_o, dm_byte_to_trans_o
  );
endinterface

// File: rtl/ma_watchdog.sv
// ma_watchdog: counts cycles while run_i is high, restarting from zero each
// time run_i drops; expired_o flags the TIMEOUT_CYCLES-th running cycle so the
// owner leaves its wait state exactly TIMEOUT_CYCLES cycles after entry.
module ma_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  output logic expired_o
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: advance while running, clear otherwise.
  always_comb begin
    cnt_d = run_i ? cnt_q + CW'(1) : '0;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = run_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/ma_mrf_dispatcher.sv
// ma_mrf_dispatcher: splits one matrix-load command into equal consecutive
// DDR4 slices, one per enabled MRF channel, sequences the datamover
// start/done handshakes and returns one completion with merged error status.
// Optional build macro: MA_DISPATCH_TIMEOUT_EN adds a WAIT-state watchdog.
module ma_mrf_dispatcher
  import ma_pkg::*;
#(
  parameter int unsigned NUM_MRF        = MA_NUM_MRF,
  parameter int unsigned DDR4_ADDRWIDTH = MA_DDR4_ADDRWIDTH,
  parameter int unsigned MRF_ADDRWIDTH  = MA_MRF_ADDRWIDTH,
  parameter int unsigned MRF_DATAWIDTH  = MA_MRF_DATAWIDTH,
  parameter int unsigned BYTES_WIDTH    = MA_BYTES_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               link_up_i,
  ma_mrf_dispatcher_if.slave bus
);
  localparam int unsigned BEAT_BYTES = ma_beat_bytes(MRF_DATAWIDTH);
  localparam int unsigned CH_W       = (NUM_MRF > 1) ? $clog2(NUM_MRF) : 1;

  if (NUM_MRF < 1 || NUM_MRF > 16 || TIMEOUT_CYCLES < 1 || BEAT_BYTES < 1) begin : g_param_check
    $error("ma_mrf_dispatcher: unsupported parameter set");
  end

  typedef struct packed {
    logic [MRF_ADDRWIDTH-1:0] dst;
    logic [BYTES_WIDTH-1:0]   bytes;
    logic [NUM_MRF-1:0]       mask;
  } cmd_t;

  ma_disp_state_e                         state_q, state_d;
  logic [CH_W-1:0]                        ch_idx_q, ch_idx_d;
  logic [DDR4_ADDRWIDTH-1:0]              src_acc_q, src_acc_d;
  cmd_t                                   cmd_q, cmd_d;
  logic [NUM_MRF-1:0]                     pending_q, pending_d;
  logic [NUM_MRF-1:0]                     err_ch_q, err_ch_d;
  logic                                   fmt_err_q, fmt_err_d;
  logic [NUM_MRF-1:0]                     start_q, start_d;
  logic [NUM_MRF-1:0][DDR4_ADDRWIDTH-1:0] src_q, src_d;
  logic [NUM_MRF-1:0][MRF_ADDRWIDTH-1:0]  dst_q, dst_d;
  logic [NUM_MRF-1:0][BYTES_WIDTH-1:0]    bytes_q, bytes_d;
  logic                                   accept, misaligned, timeout_flag;

  assign accept     = (state_q == IDLE) && link_up_i && bus.cmd_valid_i;
  assign misaligned = (32'(bus.cmd_bytes_i) % BEAT_BYTES) != 0;

`ifdef MA_DISPATCH_TIMEOUT_EN
  logic wd_expired;
  logic timeout_q, timeout_d;

  ma_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_i     (state_q == WAIT),
    .expired_o (wd_expired)
  );

  // Timeout flag register, reported with the completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timeout_q <= 1'b0;
    else        timeout_q <= timeout_d;
  end

  assign timeout_flag = timeout_q;
`else
  assign timeout_flag = 1'b0;
`endif

  // Next-state, channel issue and done/error bookkeeping.
  always_comb begin
    state_d   = state_q;
    ch_idx_d  = ch_idx_q;
    src_acc_d = src_acc_q;
    cmd_d     = cmd_q;
    pending_d = pending_q;
    err_ch_d  = err_ch_q;
    fmt_err_d = fmt_err_q;
    start_d   = '0;
    src_d     = src_q;
    dst_d     = dst_q;
    bytes_d   = bytes_q;
`ifdef MA_DISPATCH_TIMEOUT_EN
    timeout_d = timeout_q;
`endif

    // Starts are registered, so a done seen while start_q is still high
    // belongs to no transfer of ours and must not clear the fresh pending bit.
    if (state_q == ISSUE || state_q == WAIT) begin
      for (int unsigned k = 0; k < NUM_MRF; k++) begin
        if (pending_q[k] && !start_q[k] && bus.dm_done_i[k]) pending_d[k] = 1'b0;
        if (pending_q[k] && bus.dm_err_i[k])                 err_ch_d[k]  = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_d.dst  = bus.cmd_dst_bram_addr_i;
          cmd_d.bytes = bus.cmd_bytes_i;
          cmd_d.mask = bus.cmd_ch_mask_i;
          ch_idx_d   = '0;
          src_acc_d  = bus.cmd_src_addr_i;
          if (bus.cmd_bytes_i == '0 || bus.cmd_ch_mask_i == '0) begin
            state_d = DONE;
          end else if (misaligned) begin
            state_d   = DONE;
            fmt_err_d = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        for (int unsigned k = 0; k < NUM_MRF; k++) begin
          if (CH_W'(k) == ch_idx_q && cmd_q.mask[k]) begin
            start_d[k]   = 1'b1;
            src_d[k]     = src_acc_q;
            dst_d[k]     = cmd_q.dst;
            bytes_d[k]   = cmd_q.bytes;
            pending_d[k] = 1'b1;
            src_acc_d    = src_acc_q + DDR4_ADDRWIDTH'(cmd_q.bytes);
          end
        end
        if (ch_idx_q == CH_W'(NUM_MRF - 1)) state_d = WAIT;
        else                                ch_idx_d = ch_idx_q + CH_W'(1);
      end
      WAIT: begin
        if (pending_q == '0) begin
          state_d = DONE;
        end
`ifdef MA_DISPATCH_TIMEOUT_EN
        else if (wd_expired) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          err_ch_d  = err_ch_d | pending_d;
        end
`endif
      end
      DONE: begin
        state_d   = IDLE;
        pending_d = '0;
        err_ch_d  = '0;
        fmt_err_d = 1'b0;
`ifdef MA_DISPATCH_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and per-channel output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_idx_q  <= '0;
      src_acc_q <= '0;
      cmd_q     <= '0;
      pending_q <= '0;
      err_ch_q  <= '0;
      fmt_err_q <= 1'b0;
      start_q   <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      bytes_q   <= '0;
    end else begin
      state_q   <= state_d;
      ch_idx_q  <= ch_idx_d;
      src_acc_q <= src_acc_d;
      cmd_q     <= cmd_d;
      pending_q <= pending_d;
      err_ch_q  <= err_ch_d;
      fmt_err_q <= fmt_err_d;
      start_q   <= start_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      bytes_q   <= bytes_d;
    end
  end

  assign bus.cmd_ready_o        = (state_q == IDLE) && link_up_i;
  assign bus.busy_o             = (state_q != IDLE);
  assign bus.done_o             = (state_q == DONE);
  assign bus.err_o              = (state_q == DONE) && ((|err_ch_q) || fmt_err_q || timeout_flag);
  assign bus.err_ch_o           = (state_q == DONE) ? err_ch_q : '0;
  assign bus.timeout_o          = (state_q == DONE) && timeout_flag;
  assign bus.dm_start_o         = start_q;
  assign bus.dm_src_axi_addr_o  = src_q;
  assign bus.dm_dst_bram_addr_o = dst_q;
  assign bus.dm_byte_to_trans_o = bytes_q;
endmodule

// File: tb/tb_ma_mrf_dispatcher.sv
// tb_ma_mrf_dispatcher: directed vector table plus hand sequences for link-down,
// reset in WAIT and (with MA_DISPATCH_TIMEOUT_EN) the watchdog path.
module tb_ma_mrf_dispatcher;
  import ma_pkg::*;

  localparam int unsigned NUM = 4;
  localparam int unsigned AW  = 36;
  localparam int unsigned MW  = 6;
  localparam int unsigned BW  = 15;
  localparam int unsigned LAT = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic link_up;

  always #5 clk = ~clk;

  ma_mrf_dispatcher_if #(.NUM_MRF(NUM), .DDR4_ADDRWIDTH(AW), .MRF_ADDRWIDTH(MW),
                         .BYTES_WIDTH(BW)) bus ();

  ma_mrf_dispatcher #(
    .NUM_MRF(NUM), .DDR4_ADDRWIDTH(AW), .MRF_ADDRWIDTH(MW), .MRF_DATAWIDTH(1024),
    .BYTES_WIDTH(BW), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .link_up_i (link_up),
    .bus       (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Datamover model: done LAT cycles after each start, optional error pulse
  // one cycle before done, optional never-done channels.
  logic [NUM-1:0] err_mask, never_mask;
  logic [AW-1:0]  obs_addr  [NUM];
  logic [MW-1:0]  obs_dst   [NUM];
  logic [BW-1:0]  obs_bytes [NUM];
  int unsigned    obs_cycle [NUM];
  int unsigned    start_total = 0;

  initial begin
    int unsigned cd [NUM];
    for (int k = 0; k < NUM; k++) cd[k] = 0;
    bus.dm_done_i = '0;
    bus.dm_err_i  = '0;
    forever begin
      @(negedge clk);
      bus.dm_done_i = '0;
      bus.dm_err_i  = '0;
      if (!rst_n) begin
        for (int k = 0; k < NUM; k++) cd[k] = 0;
      end else begin
        for (int k = 0; k < NUM; k++) begin
          if (bus.dm_start_o[k]) begin
            cd[k]        = LAT;
            obs_addr[k]  = bus.dm_src_axi_addr_o[k];
            obs_dst[k]   = bus.dm_dst_bram_addr_o[k];
            obs_bytes[k] = bus.dm_byte_to_trans_o[k];
            obs_cycle[k] = cyc;
            start_total++;
          end else if (cd[k] != 0) begin
            cd[k]--;
            if (cd[k] == 1 && err_mask[k])    bus.dm_err_i[k]  = 1'b1;
            if (cd[k] == 0 && !never_mask[k]) bus.dm_done_i[k] = 1'b1;
          end
        end
      end
    end
  end

  typedef struct {
    ma_mrf_cmd_t             cmd;
    logic [NUM-1:0]          err_inj;
    logic                    exp_err;
    logic [NUM-1:0]          exp_errch;
    int unsigned             exp_starts;
    logic [NUM-1:0][AW-1:0]  exp_addr;
    int unsigned             exp_lat;
  } vec_t;

  function automatic vec_t mk(input logic [AW-1:0] src, input logic [MW-1:0] dst,
                              input int unsigned bytes, input logic [NUM-1:0] mask,
                              input logic [NUM-1:0] err_inj, input logic exp_err,
                              input logic [NUM-1:0] exp_errch, input int unsigned exp_starts,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                              input int unsigned exp_lat);
    vec_t v;
    v.cmd.src     = src;
    v.cmd.dst     = dst;
    v.cmd.bytes   = BW'(bytes);
    v.cmd.mask    = mask;
    v.err_inj     = err_inj;
    v.exp_err     = exp_err;
    v.exp_errch   = exp_errch;
    v.exp_starts  = exp_starts;
    v.exp_addr[0] = a0;
    v.exp_addr[1] = a1;
    v.exp_addr[2] = a2;
    v.exp_addr[3] = a3;
    v.exp_lat     = exp_lat;
    return v;
  endfunction

  // Issue one command, then wait (bounded) for its completion pulse.
  task automatic run_cmd(input string tag, input ma_mrf_cmd_t c,
                         output logic got_done, output logic got_err,
                         output logic [NUM-1:0] got_errch, output logic got_to,
                         output int unsigned lat, output int unsigned done_cyc);
    int unsigned w;
    got_done = 1'b0; got_err = 1'b0; got_errch = '0; got_to = 1'b0;
    lat = 0; done_cyc = 0;
    @(negedge clk);
    bus.cmd_valid_i         = 1'b1;
    bus.cmd_src_addr_i      = c.src;
    bus.cmd_dst_bram_addr_i = c.dst;
    bus.cmd_bytes_i         = c.bytes;
    bus.cmd_ch_mask_i       = c.mask;
    w = 0;
    while (!bus.cmd_ready_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.cmd_ready_o) begin
      chk({tag, "_accept"}, 64'(bus.cmd_ready_o), 64'd1);
      bus.cmd_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    // Command fields are scrambled after acceptance; the DUT must ignore them.
    bus.cmd_valid_i         = 1'b0;
    bus.cmd_src_addr_i      = ~c.src;
    bus.cmd_dst_bram_addr_i = ~c.dst;
    bus.cmd_bytes_i         = ~c.bytes;
    bus.cmd_ch_mask_i       = ~c.mask;
    lat = 1;
    while (!bus.done_o && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done_o) begin
      chk({tag, "_done_timeout"}, 64'(bus.done_o), 64'd1);
      return;
    end
    got_done  = 1'b1;
    got_err   = bus.err_o;
    got_errch = bus.err_ch_o;
    got_to    = bus.timeout_o;
    done_cyc  = cyc;
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'(bus.done_o), 64'd0);
    chk({tag, "_idle_after"},     64'(bus.busy_o), 64'd0);
  endtask

  vec_t vecs [8];

  initial begin
    logic           d, e, t;
    logic [NUM-1:0] ech;
    int unsigned    lat, dcyc, s0;
    string          tg;
    ma_mrf_cmd_t    c;

    begin : global_watchdog_spawn
      fork
        begin
          #500000;
          $display("FAIL global_timeout: got=running expected=finished");
          $fatal(1, "bench time limit");
        end
      join_none
    end

    vecs[0] = mk(36'h1000, 6'd5, 8192, 4'hF, 4'h0, 1'b0, 4'h0, 4,
                 36'h1000, 36'h3000, 36'h5000, 36'h7000, 0);
    vecs[1] = mk(36'h0, 6'd9, 256, 4'hA, 4'h0, 1'b0, 4'h0, 2,
                 36'h0, 36'h0, 36'h0, 36'h100, 0);
    vecs[2] = mk(36'h4000, 6'd1, 100, 4'hF, 4'h0, 1'b1, 4'h0, 0,
                 36'h0, 36'h0, 36'h0, 36'h0, 1);
    vecs[3] = mk(36'h4000, 6'd1, 0, 4'hF, 4'h0, 1'b0, 4'h0, 0,
                 36'h0, 36'h0, 36'h0, 36'h0, 1);
    vecs[4] = mk(36'h4000, 6'd1, 256, 4'h0, 4'h0, 1'b0, 4'h0, 0,
                 36'h0, 36'h0, 36'h0, 36'h0, 1);
    vecs[5] = mk(36'h2000, 6'd33, 128, 4'hF, 4'b0100, 1'b1, 4'b0100, 4,
                 36'h2000, 36'h2080, 36'h2100, 36'h2180, 0);
    vecs[6] = mk(36'h2000, 6'd34, 128, 4'hF, 4'h0, 1'b0, 4'h0, 4,
                 36'h2000, 36'h2080, 36'h2100, 36'h2180, 0);
    vecs[7] = mk(36'hF_FFFF_FF80, 6'd63, 128, 4'b0011, 4'h0, 1'b0, 4'h0, 2,
                 36'hF_FFFF_FF80, 36'h0, 36'h0, 36'h0, 0);

    err_mask   = '0;
    never_mask = '0;
    link_up    = 1'b1;
    rst_n      = 1'b0;
    bus.cmd_valid_i         = 1'b0;
    bus.cmd_src_addr_i      = '0;
    bus.cmd_dst_bram_addr_i = '0;
    bus.cmd_bytes_i         = '0;
    bus.cmd_ch_mask_i       = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ready",     64'(bus.cmd_ready_o), 64'd1);
    chk("rst_busy",      64'(bus.busy_o), 64'd0);
    chk("rst_done",      64'(bus.done_o), 64'd0);
    chk("rst_err",       64'(bus.err_o), 64'd0);
    chk("rst_err_ch",    64'(bus.err_ch_o), 64'd0);
    chk("rst_timeout",   64'(bus.timeout_o), 64'd0);
    chk("rst_start",     64'(bus.dm_start_o), 64'd0);
    chk("rst_src0",      64'(bus.dm_src_axi_addr_o[0]), 64'd0);
    chk("rst_bytes3",    64'(bus.dm_byte_to_trans_o[3]), 64'd0);
    rst_n = 1'b1;

    // Link down blocks acceptance.
    @(negedge clk);
    link_up = 1'b0;
    bus.cmd_valid_i   = 1'b1;
    bus.cmd_bytes_i   = BW'(128);
    bus.cmd_ch_mask_i = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("linkdown_ready_%0d", i), 64'(bus.cmd_ready_o), 64'd0);
      chk($sformatf("linkdown_busy_%0d", i),  64'(bus.busy_o), 64'd0);
    end
    bus.cmd_valid_i = 1'b0;
    link_up = 1'b1;

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      tg = $sformatf("v%0d", i);
      err_mask = vecs[i].err_inj;
      s0 = start_total;
      run_cmd(tg, vecs[i].cmd, d, e, ech, t, lat, dcyc);
      err_mask = '0;
      chk({tg, "_done"},    64'(d), 64'd1);
      chk({tg, "_err"},     64'(e), 64'(vecs[i].exp_err));
      chk({tg, "_err_ch"},  64'(ech), 64'(vecs[i].exp_errch));
      chk({tg, "_timeout"}, 64'(t), 64'd0);
      chk({tg, "_starts"},  64'(start_total - s0), 64'(vecs[i].exp_starts));
      if (vecs[i].exp_lat != 0)
        chk({tg, "_latency"}, 64'(lat), 64'(vecs[i].exp_lat));
      for (int k = 0; k < NUM; k++) begin
        if (vecs[i].cmd.mask[k] && vecs[i].exp_starts != 0) begin
          chk($sformatf("%s_addr%0d", tg, k),  64'(obs_addr[k]),  64'(vecs[i].exp_addr[k]));
          chk($sformatf("%s_dst%0d", tg, k),   64'(obs_dst[k]),   64'(vecs[i].cmd.dst));
          chk($sformatf("%s_bytes%0d", tg, k), 64'(obs_bytes[k]), 64'(vecs[i].cmd.bytes));
          if (vecs[i].cmd.mask == 4'hF)
            chk($sformatf("%s_issue_cyc%0d", tg, k), 64'(obs_cycle[k] - obs_cycle[0]), 64'(k));
        end
      end
    end

    // Reset while waiting on datamovers: no completion, state cleared.
    never_mask = 4'hF;
    @(negedge clk);
    bus.cmd_valid_i         = 1'b1;
    bus.cmd_src_addr_i      = 36'h8000;
    bus.cmd_dst_bram_addr_i = 6'd2;
    bus.cmd_bytes_i         = BW'(128);
    bus.cmd_ch_mask_i       = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    repeat (8) @(negedge clk);
    chk("rstwait_busy_before", 64'(bus.busy_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstwait_busy",  64'(bus.busy_o), 64'd0);
    chk("rstwait_done",  64'(bus.done_o), 64'd0);
    chk("rstwait_src1",  64'(bus.dm_src_axi_addr_o[1]), 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rstwait_no_done", 64'(bus.done_o), 64'd0);
    end
    rst_n = 1'b1;
    never_mask = '0;
    c = vecs[6].cmd;
    run_cmd("post_rst", c, d, e, ech, t, lat, dcyc);
    chk("post_rst_done", 64'(d), 64'd1);
    chk("post_rst_err",  64'(e), 64'd0);

`ifdef MA_DISPATCH_TIMEOUT_EN
    // Channel 3 never completes: watchdog closes the command.
    never_mask = 4'b1000;
    c = vecs[6].cmd;
    run_cmd("wdog", c, d, e, ech, t, lat, dcyc);
    never_mask = '0;
    chk("wdog_done",    64'(d), 64'd1);
    chk("wdog_timeout", 64'(t), 64'd1);
    chk("wdog_err",     64'(e), 64'd1);
    chk("wdog_err_ch",  64'(ech), 64'h8);
    chk("wdog_latency", 64'(dcyc - obs_cycle[3]), 64'd100);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ma_mrf_dispatcher.md
Name: ma_mrf_dispatcher

Overview:
- Parametrised successor to the fixed four-way MRF load path in the memory-access unit.
- Accepts one matrix-load command and splits it into consecutive, equal-size DDR4 slices, one per enabled MRF channel (NUM_MRF channels).
- Sequences the per-channel axi2bram datamover start/done handshakes, collects per-channel read errors, and returns a single completion with error status.
- Sits between ma_controller and the per-channel axi2bram_datamover instances.

Parameters:
- NUM_MRF, 4: number of MRF channels/datamovers (1..16).
- DDR4_ADDRWIDTH, 36: AXI byte-address width.
- MRF_ADDRWIDTH, 6: MRF BRAM word-address width.
- MRF_DATAWIDTH, 1024: MRF word width in bits; beat size BEAT_BYTES = MRF_DATAWIDTH/8.
- BYTES_WIDTH, 15: width of byte-count fields.
- TIMEOUT_CYCLES, 65535: watchdog limit, used only with MA_DISPATCH_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- link_up_i  in  1  all DDR4 calibrated; commands accepted only when high
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_src_addr_i  in  DDR4_ADDRWIDTH  DDR4 byte address of slice 0
- cmd_dst_bram_addr_i  in  MRF_ADDRWIDTH  BRAM word address, same for every channel
- cmd_bytes_i  in  BYTES_WIDTH  bytes per channel slice
- cmd_ch_mask_i  in  NUM_MRF  enabled channels
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  error status, valid with done_o
- err_ch_o  out  NUM_MRF  per-channel error bits, valid with done_o
- timeout_o  out  1  watchdog expiry, valid with done_o (0 if feature off)
- busy_o  out  1  not IDLE
- dm_start_o  out  NUM_MRF  one-cycle start per datamover
- dm_src_axi_addr_o  out  NUM_MRF x DDR4_ADDRWIDTH  slice source address
- dm_dst_bram_addr_o  out  NUM_MRF x MRF_ADDRWIDTH  BRAM address
- dm_byte_to_trans_o  out  NUM_MRF x BYTES_WIDTH  slice byte count
- dm_done_i  in  NUM_MRF  datamover done pulses
- dm_err_i  in  NUM_MRF  datamover non-OKAY rresp pulse

Behaviour:
- Reset values: all outputs 0, except cmd_ready_o = link_up_i (combinational from IDLE). Per-channel address/count registers are 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - cmd_ready_o = link_up_i.
  - On accept, latch all command fields, set ch_idx = 0 and src_acc = cmd_src_addr_i.
  - If cmd_bytes_i == 0 or cmd_ch_mask_i == 0, go to DONE with err_o = 0.
  - If cmd_bytes_i % BEAT_BYTES != 0, go to DONE with err_o = 1 and err_ch_o = 0. No starts are issued in either case.
  - Otherwise go to ISSUE.
- ISSUE: visits one channel per cycle, ch_idx 0..NUM_MRF-1.
  - Enabled channel: pulse dm_start_o[ch_idx] for exactly one cycle, with dm_src_axi_addr_o = src_acc, dm_dst_bram_addr_o = latched dst, dm_byte_to_trans_o = latched bytes. Set pending[ch_idx]; src_acc += bytes, wrapping modulo 2^DDR4_ADDRWIDTH.
  - Disabled channel: skipped, no start, src_acc unchanged.
  - Per-channel address/count outputs are registered and held until the next start to that channel.
  - After ch_idx = NUM_MRF-1, go to WAIT.
- ISSUE latency: NUM_MRF cycles regardless of mask.
- Done/error tracking (ISSUE and WAIT):
  - dm_done_i[k] clears pending[k].
  - dm_err_i[k] sets sticky err_ch[k].
  - A done or err pulse on a non-pending channel is ignored.
  - A done pulse in the same cycle as that channel's start is ignored, since the set wins.
- WAIT → DONE when pending == 0.
- DONE: one cycle. done_o = 1, err_o = |err_ch, err_ch_o = err_ch. Then clear err_ch and pending and return to IDLE.
  - First acceptance of a new command is one cycle after DONE.
- Command inputs are sampled only on accept; changes outside acceptance are ignored.
- link_up_i falling mid-command does not abort; it only blocks the next accept.
- Reset mid-operation: FSM returns to IDLE, pending/err cleared, no done_o. Datamovers are reset by the same rst_n.

Optional Feature:
- MA_DISPATCH_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT and clears on entry to WAIT.
  - When the counter reaches TIMEOUT_CYCLES with pending != 0, go to DONE with timeout_o = 1, err_o = 1, and err_ch_o = err_ch | pending.
  - Late dm_done_i pulses arriving after that are ignored.
- Undefined: no counter; timeout_o is tied to 0; WAIT waits indefinitely.

Decomposition:
- Package ma_pkg:
  - typedef ma_disp_state_e {IDLE, ISSUE, WAIT, DONE}
  - function to compute beat bytes from data width
  - ma_mrf_cmd_t struct (src, dst, bytes, mask)
- Sub-module: none required. Optional ma_watchdog (counter + expiry), instantiated only under MA_DISPATCH_TIMEOUT_EN.

Test Plan:
- NUM_MRF = 4, mask 4'b1111, src 0x1000, bytes 8192, dm_done 5 cycles after each start → starts on channels 0..3 in consecutive cycles, src 0x1000/0x3000/0x5000/0x7000, single done_o, err_o = 0.
- Mask 4'b1010, src 0x0, bytes 256 → starts only on ch1 (addr 0x0) and ch3 (addr 0x100); done_o after both done pulses.
- bytes 100 (not a multiple of 128) → no dm_start_o, done_o 1 cycle after accept, err_o = 1, err_ch_o = 0. bytes 0 or mask 0 → done_o with err_o = 0.
- dm_err_i[2] pulse during WAIT, all channels complete → err_o = 1, err_ch_o = 4'b0100. Next command reports err_o = 0.
- src 0xF_FFFF_FF80, bytes 128, mask 4'b0011 → ch1 address wraps to 0x0. link_up_i = 0 holds cmd_ready_o low. rst_n asserted in WAIT → busy_o = 0, no done_o.
- MA_DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES = 100, ch3 never done → done_o at WAIT entry + 100, timeout_o = 1, err_ch_o = 4'b1000.
